// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART serial stages.
// Used by the transmitter today and by the receiver later.
package fifo_uart_tx_pkg;

    localparam int   DEF_PWIDTH    = 16;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period counter: counts 0..i_period while running and ticks on the last cycle.
// i_restart forces the count back to 0 so a new bit period starts next cycle.
module uart_bit_timer #(
    parameter int PWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_restart,
    input  logic              i_run,
    input  logic [PWIDTH-1:0] i_period,
    output logic              o_tick
);

    logic [PWIDTH-1:0] r_cnt;
    logic              w_tick;

    assign w_tick = i_run && (r_cnt == i_period);
    assign o_tick = w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || !i_run || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a FIFO and sends them as start/data/parity/stop frames; start bit one cycle after pop.
// Pops only when idle or finishing the last stop bit, with en high and the FIFO non-empty.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = DEF_PWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PWIDTH-1:0] prescale,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              stop2,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] LAST_BIT = 4'(DWIDTH - 1);

    uart_state_t       r_state, w_state_nxt;
    logic [DWIDTH-1:0] r_shift, w_shift_nxt;
    logic [3:0]        r_bitcnt, w_bitcnt_nxt;
    logic              r_txd, w_txd_nxt;
    logic              r_done;
    logic [PWIDTH-1:0] r_prescale;
    logic              r_par_en;
    logic              r_stop2;
    logic              r_par;
    logic              w_tick;
    logic              w_final_stop;
    logic              w_pop;

    uart_bit_timer #(
        .PWIDTH (PWIDTH)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_pop),
        .i_run     (r_state != ST_IDLE),
        .i_period  (r_prescale),
        .o_tick    (w_tick)
    );

    // r_bitcnt doubles as the stop-bit index while in STOP.
    assign w_final_stop = (r_state == ST_STOP) && w_tick && (!r_stop2 || (r_bitcnt == 4'd1));
    assign w_pop        = ((r_state == ST_IDLE) || w_final_stop) && en && !fifo_empty && !rst;

    assign fifo_rd = w_pop;
    assign txd     = r_txd;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_txd_nxt    = r_txd;

        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = UART_IDLE_LVL;
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt  = ST_DATA;
                    w_txd_nxt    = r_shift[0];
                    w_bitcnt_nxt = 4'd0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bitcnt == LAST_BIT) begin
                        w_bitcnt_nxt = 4'd0;
                        if (r_par_en) begin
                            w_state_nxt = ST_PARITY;
                            w_txd_nxt   = r_par;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_txd_nxt   = UART_IDLE_LVL;
                        end
                    end else begin
                        w_shift_nxt  = {1'b0, r_shift[DWIDTH-1:1]};
                        w_txd_nxt    = r_shift[1];
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt  = ST_STOP;
                    w_txd_nxt    = UART_IDLE_LVL;
                    w_bitcnt_nxt = 4'd0;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (w_final_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end
                    w_txd_nxt = UART_IDLE_LVL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_txd_nxt   = UART_IDLE_LVL;
            end
        endcase

        // A pop overrides whatever the current frame would do next.
        if (w_pop) begin
            w_state_nxt  = ST_START;
            w_shift_nxt  = fifo_rdata;
            w_bitcnt_nxt = 4'd0;
            w_txd_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_txd      <= UART_IDLE_LVL;
            r_done     <= 1'b0;
            r_prescale <= '0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_par      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_txd    <= w_txd_nxt;
            r_done   <= w_final_stop;
            if (w_pop) begin
                r_prescale <= prescale;
                r_par_en   <= par_en;
                r_stop2    <= stop2;
                r_par      <= (^fifo_rdata) ^ par_odd;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, frame-level scoreboard, vector table and corner-case sequences.
module tb_fifo_uart_tx;

    localparam int DW = 8;
    localparam int PW = 16;
    localparam int HMAX = 32768;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          par_en = 1'b0;
    logic          par_odd = 1'b0;
    logic          stop2 = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd, txd, busy, done;

    fifo_uart_tx #(.DWIDTH(DW), .PWIDTH(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .stop2      (stop2),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .txd        (txd),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [DW-1:0] fq[$];
    bit            pop_pending = 1'b0;
    bit            exp_q[$];
    bit            done_due = 1'b0;
    int            pop_cyc[$];
    int            done_cyc[$];
    bit            hist_txd[0:HMAX-1];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: a frame is a list of line levels, each repeated for one bit period.
    function automatic void push_frame(input logic [DW-1:0] w, input int p,
                                       input bit pe, input bit po, input bit s2);
        bit bits[$];
        int ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (pe) bits.push_back(bit'(ones % 2) ^ po);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k <= p; k++) exp_q.push_back(bits[i]);
    endfunction

    always @(negedge clk) begin
        bit e_txd, e_busy, e_done, e_rd, fin;
        int sz;
        sz = exp_q.size();
        if (rst) begin
            e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; fin = 1'b0;
        end else begin
            e_txd  = (sz > 0) ? exp_q[0] : 1'b1;
            e_busy = (sz > 0);
            e_done = done_due;
            fin    = (sz == 1);
            e_rd   = ((sz == 0) || fin) && en && !fifo_empty;
        end
        chk("txd", int'(txd), int'(e_txd));
        chk("busy", int'(busy), int'(e_busy));
        chk("done", int'(done), int'(e_done));
        chk("fifo_rd", int'(fifo_rd), int'(e_rd));
        if (cyc < HMAX) hist_txd[cyc] = txd;
        if (fifo_rd === 1'b1) pop_cyc.push_back(cyc);
        if (done === 1'b1) done_cyc.push_back(cyc);
        pop_pending = (fifo_rd === 1'b1);
        if (rst) begin
            exp_q.delete();
            done_due = 1'b0;
        end else begin
            if (sz > 0) void'(exp_q.pop_front());
            done_due = fin;
            if (e_rd) push_frame(fifo_rdata, int'(prescale), par_en, par_odd, stop2);
        end
        cyc++;
    end

    task automatic fifo_update();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() == 0) ? '0 : fq[0];
    endtask

    // The FIFO pops on the clock edge that sampled fifo_rd.
    always @(posedge clk) begin
        #1;
        if (pop_pending && fq.size() > 0) void'(fq.pop_front());
        pop_pending = 1'b0;
        fifo_update();
    end

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_update();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_dones(input int n, input int bound);
        int k = 0;
        while (done_cyc.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk("done_timeout", int'(done_cyc.size() >= n), 1);
    endtask

    task automatic wait_pop(input int bound);
        int k = 0;
        while (pop_cyc.size() < 1 && k < bound) begin
            tick();
            k++;
        end
        chk("pop_timeout", int'(pop_cyc.size() >= 1), 1);
    endtask

    function automatic logic [DW-1:0] decode(input int s, input int p);
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i++) d[i] = hist_txd[s + (1 + i) * (p + 1) + p / 2];
        return d;
    endfunction

    function automatic void clear_rec();
        pop_cyc.delete();
        done_cyc.delete();
    endfunction

    typedef struct {
        logic [DW-1:0] word;
        int            p;
        bit            pe;
        bit            po;
        bit            s2;
        int            exp_len;
        bit            exp_par;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int s;
        int ones;
        tbl[0] = '{8'hA5, 3, 1'b0, 1'b0, 1'b0, 40, 1'b0};
        tbl[1] = '{8'hA5, 3, 1'b1, 1'b0, 1'b0, 44, 1'b0};
        tbl[2] = '{8'hA5, 3, 1'b1, 1'b1, 1'b0, 44, 1'b1};
        tbl[3] = '{8'hA5, 3, 1'b1, 1'b1, 1'b1, 48, 1'b1};
        tbl[4] = '{8'h01, 0, 1'b1, 1'b0, 1'b0, 11, 1'b1};
        tbl[5] = '{8'h80, 1, 1'b1, 1'b1, 1'b1, 24, 1'b0};
        tbl[6] = '{8'h3C, 2, 1'b0, 1'b0, 1'b1, 33, 1'b0};

        #1 rst = 1'b1;
        repeat (3) tick();
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fifo_rd", int'(fifo_rd), 0);
        rst = 1'b0;
        en  = 1'b1;
        tick();

        foreach (tbl[v]) begin
            prescale = PW'(tbl[v].p);
            par_en   = tbl[v].pe;
            par_odd  = tbl[v].po;
            stop2    = tbl[v].s2;
            clear_rec();
            push(tbl[v].word);
            wait_dones(1, 400);
            repeat (3) tick();
            chk("vec_pops", pop_cyc.size(), 1);
            if (pop_cyc.size() >= 1 && done_cyc.size() >= 1) begin
                s = pop_cyc[0] + 1;
                chk("vec_len", done_cyc[0] - s, tbl[v].exp_len);
                chk("vec_start", int'(hist_txd[s + tbl[v].p / 2]), 0);
                chk("vec_data", int'(decode(s, tbl[v].p)), int'(tbl[v].word));
                if (tbl[v].pe)
                    chk("vec_parity", int'(hist_txd[s + 9 * (tbl[v].p + 1) + tbl[v].p / 2]), int'(tbl[v].exp_par));
                chk("vec_stop", int'(hist_txd[s + (9 + int'(tbl[v].pe)) * (tbl[v].p + 1) + tbl[v].p / 2]), 1);
            end
            chk("vec_idle_busy", int'(busy), 0);
        end

        // Back-to-back frames at one cycle per bit.
        prescale = '0; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        clear_rec();
        fq.push_back(8'h01);
        push(8'h80);
        wait_dones(2, 100);
        tick();
        chk("b2b_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() >= 2 && done_cyc.size() >= 2) begin
            s = pop_cyc[0] + 1;
            chk("b2b_pop_gap", pop_cyc[1] - pop_cyc[0], 10);
            chk("b2b_done0", done_cyc[0] - s, 10);
            chk("b2b_done1", done_cyc[1] - s, 20);
            chk("b2b_bit7", int'(hist_txd[s + 8]), 0);
            chk("b2b_stop", int'(hist_txd[s + 9]), 1);
            chk("b2b_start2", int'(hist_txd[s + 10]), 0);
            chk("b2b_data2", int'(decode(s + 10, 0)), 8'h80);
        end

        // Empty FIFO with en high.
        clear_rec();
        ones = 0;
        s = cyc;
        repeat (100) tick();
        for (int i = s; i < s + 100; i++) ones += int'(hist_txd[i]);
        chk("empty_pops", pop_cyc.size(), 0);
        chk("empty_txd_high", ones, 100);
        chk("empty_busy", int'(busy), 0);

        // en dropped during the data bits of the first of two words.
        prescale = PW'(1);
        clear_rec();
        fq.push_back(8'h55);
        push(8'hAA);
        wait_pop(20);
        repeat (5) tick();
        en = 1'b0;
        wait_dones(1, 100);
        repeat (30) tick();
        chk("en_pops", pop_cyc.size(), 1);
        chk("en_busy", int'(busy), 0);
        chk("en_fifo_left", fq.size(), 1);
        en = 1'b1;
        wait_dones(2, 100);
        tick();

        // Reset pulse during data bit 3 at prescale 7.
        prescale = PW'(7);
        clear_rec();
        fq.push_back(8'h96);
        push(8'h3B);
        wait_pop(20);
        if (pop_cyc.size() >= 1) begin
            s = pop_cyc[0] + 1;
            while (cyc < s + 4 * 8 + 3) tick();
        end
        rst = 1'b1;
        #1;
        chk("rstmid_txd", int'(txd), 1);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_fifo_rd", int'(fifo_rd), 0);
        tick();
        rst = 1'b0;
        clear_rec();
        wait_dones(1, 200);
        tick();
        chk("rstmid_pops", pop_cyc.size(), 1);
        if (pop_cyc.size() >= 1 && done_cyc.size() >= 1) begin
            s = pop_cyc[0] + 1;
            chk("rstmid_len", done_cyc[0] - s, 80);
            chk("rstmid_data", int'(decode(s, 7)), 8'h3B);
        end

        // Random traffic, config churn, en toggling and rare resets.
        prescale = '0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0 && fq.size() < 8) push(DW'($urandom));
            if ($urandom_range(0, 24) == 0) en = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 29) == 0) begin
                prescale = PW'($urandom_range(0, 3));
                par_en   = 1'($urandom);
                par_odd  = 1'($urandom);
                stop2    = 1'($urandom);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
        begin
            int k = 0;
            while ((fq.size() != 0 || busy) && k < 3000) begin
                tick();
                k++;
            end
        end
        repeat (3) tick();
        chk("drain_fifo", fq.size(), 0);
        chk("drain_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
